// File: rtl/fir_coef_loader_pkg.sv
// fir_coef_loader_pkg: default coefficient width, loader FSM states and index-width helper
package fir_coef_loader_pkg;
  localparam int COEFW_DEF = 18;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, COMMIT} state_t;
  function automatic int clog2(input int v);
    int r = 1;
    for (int i = 1; i < 31; i++) r = ((1 << i) < v) ? i + 1 : r;
    return r;
  endfunction
endpackage

// File: rtl/fir_coef_bank.sv
// fir_coef_bank: per-tap shadow and active coefficient registers, flattened active bank out
module fir_coef_bank import fir_coef_loader_pkg::*; #(
  parameter int NTAPS = 32,
  parameter int COEFW = COEFW_DEF,
  parameter int NLOAD = NTAPS,
  parameter int IW = clog2(NLOAD)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [IW-1:0]          idx,
  input  logic [COEFW-1:0]       din,
  input  logic                   commit,
  output logic [NTAPS*COEFW-1:0] coefs
);
  for (genvar t = 0; t < NTAPS; t++) begin : g_tap
    // taps past the loaded half take the word of their mirror tap
    localparam int K = (t < NLOAD) ? t : NTAPS - 1 - t;
    logic [COEFW-1:0] shadow, active;
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        shadow <= '0;
        active <= '0;
      end else begin
        if (we && idx == IW'(K)) shadow <= din;
        if (commit) active <= shadow;
      end
    assign coefs[t*COEFW +: COEFW] = active;
  end
endmodule

// File: rtl/fir_coef_loader.sv
// fir_coef_loader: stream coefficient frames into a shadow bank, commit only complete frames.
// FIR_COEF_SYMMETRIC_EN: load (NTAPS+1)/2 words and mirror each onto tap NTAPS-1-k.
module fir_coef_loader import fir_coef_loader_pkg::*; #(
  parameter int NTAPS = 32,
  parameter int COEFW = COEFW_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [COEFW-1:0]       s_coef_data,
  input  logic                   s_coef_valid,
  input  logic                   s_coef_last,
  output logic                   s_coef_ready,
  output logic [NTAPS*COEFW-1:0] coefs,
  output logic                   coef_update,
  output logic                   load_err,
  output logic                   busy
);
`ifdef FIR_COEF_SYMMETRIC_EN
  localparam int NLOAD = (NTAPS + 1) / 2;
`else
  localparam int NLOAD = NTAPS;
`endif
  localparam int IW = clog2(NLOAD);
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic run, xfer, at_end, we, err_n;
  assign xfer = s_coef_valid && s_coef_ready;
  assign at_end = idx == IW'(NLOAD - 1);
  assign s_coef_ready = run && state != COMMIT;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      idx <= '0;
      run <= 1'b0;
      coef_update <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      run <= 1'b1;
      coef_update <= state == COMMIT;
      load_err <= err_n;
    end
  // IDLE behaves as LOAD at idx 0, so a one-word frame is judged by the same length check
  always_comb begin
    state_n = state;
    idx_n = idx;
    we = 1'b0;
    err_n = 1'b0;
    case (state)
      IDLE, LOAD: if (xfer) begin
        we = 1'b1;
        state_n = s_coef_last ? (at_end ? COMMIT : IDLE) : (at_end ? DRAIN : LOAD);
        idx_n = s_coef_last ? '0 : at_end ? idx : idx + 1'b1;
        err_n = s_coef_last && !at_end;
      end
      DRAIN: if (xfer && s_coef_last) begin
        state_n = IDLE;
        idx_n = '0;
        err_n = 1'b1;
      end
      default: begin
        state_n = IDLE;
        idx_n = '0;
      end
    endcase
  end
  fir_coef_bank #(.NTAPS(NTAPS), .COEFW(COEFW), .NLOAD(NLOAD), .IW(IW)) u_bank (
    .clk(clk),
    .reset(reset),
    .we(we),
    .idx(idx),
    .din(s_coef_data),
    .commit(state == COMMIT),
    .coefs(coefs)
  );
endmodule

// File: tb/tb_fir_coef_loader.sv
// tb_fir_coef_loader: scoreboarded frame tests for fir_coef_loader (FIR_COEF_SYMMETRIC_EN selects NTAPS=5)
module tb_fir_coef_loader;
`ifdef FIR_COEF_SYMMETRIC_EN
  localparam int NTAPS = 5;
  localparam int NL = (NTAPS + 1) / 2;
`else
  localparam int NTAPS = 32;
  localparam int NL = NTAPS;
`endif
  localparam int COEFW = 18;
  localparam int VW = NTAPS * COEFW;
  logic clk = 0, reset = 0;
  logic [COEFW-1:0] s_coef_data = '0;
  logic s_coef_valid = 0, s_coef_last = 0;
  logic s_coef_ready, coef_update, load_err, busy;
  logic [VW-1:0] coefs;
  int n_chk = 0, n_fail = 0, upd_cnt = 0, err_cnt = 0;
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] bank = '0, mon_e;
  logic [COEFW-1:0] w[64];
  always #5 clk = ~clk;
  fir_coef_loader #(.NTAPS(NTAPS), .COEFW(COEFW)) dut (
    .clk(clk), .reset(reset), .s_coef_data(s_coef_data), .s_coef_valid(s_coef_valid),
    .s_coef_last(s_coef_last), .s_coef_ready(s_coef_ready), .coefs(coefs),
    .coef_update(coef_update), .load_err(load_err), .busy(busy)
  );
  always @(negedge clk) if (reset) begin
    if (load_err) err_cnt++;
    if (coef_update) begin
      upd_cnt++;
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL update_unexpected coefs=%h", coefs);
      end else begin
        mon_e = exp_q.pop_front();
        if (coefs !== mon_e) begin
          n_fail++;
          $display("FAIL update_coefs got %h want %h", coefs, mon_e);
        end
      end
    end
  end
  function automatic logic [VW-1:0] image();
    logic [VW-1:0] v;
    for (int t = 0; t < NTAPS; t++) v[t*COEFW +: COEFW] = w[t < NL ? t : NTAPS - 1 - t];
    return v;
  endfunction
  task automatic put(input logic [COEFW-1:0] d, input bit l);
    int t = 0;
    s_coef_data = d;
    s_coef_valid = 1;
    s_coef_last = l;
    @(negedge clk);
    while (!s_coef_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_chk++;
    if (s_coef_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL handshake_timeout ready=%b want 1", s_coef_ready);
    end
    @(posedge clk);
    #1;
    s_coef_valid = 0;
    s_coef_last = 0;
    s_coef_data = COEFW'($urandom);
  endtask
  task automatic send(input int n, input bit gaps, input bit good);
    if (good) begin
      bank = image();
      exp_q.push_back(bank);
    end
    for (int k = 0; k < n; k++) begin
      put(w[k], k == n - 1);
      if (gaps && k % 3 == 1 && k != n - 1) begin
        @(posedge clk);
        #1;
      end
    end
  endtask
  task automatic fill_random();
    for (int k = 0; k < 64; k++) w[k] = COEFW'($urandom);
  endtask
  task automatic test_reset();
    reset = 0;
    s_coef_valid = 1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({s_coef_ready, coef_update, load_err, busy} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_outputs ready/upd/err/busy=%b want 0000", {s_coef_ready, coef_update, load_err, busy});
    end
    n_chk++;
    if (coefs !== '0) begin
      n_fail++;
      $display("FAIL reset_coefs got %h want 0", coefs);
    end
    s_coef_valid = 0;
    reset = 1;
    @(posedge clk);
    #1;
    n_chk++;
    if (s_coef_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready got %b want 1", s_coef_ready);
    end
  endtask
  task automatic test_full_frame();
    for (int k = 0; k < NTAPS; k++) w[k] = COEFW'(k + 1);
    send(NTAPS, 0, 1);
    n_chk++;
    if ({s_coef_ready, busy, coef_update} !== 3'b010) begin
      n_fail++;
      $display("FAIL commit_cycle ready/busy/upd=%b want 010", {s_coef_ready, busy, coef_update});
    end
    @(posedge clk);
    #1;
    n_chk++;
    if ({s_coef_ready, busy, coef_update} !== 3'b101) begin
      n_fail++;
      $display("FAIL after_commit ready/busy/upd=%b want 101", {s_coef_ready, busy, coef_update});
    end
    n_chk++;
    if (coefs[31*COEFW +: COEFW] !== COEFW'(32) || coefs[0 +: COEFW] !== COEFW'(1)) begin
      n_fail++;
      $display("FAIL full_taps tap0=%0d tap31=%0d want 1 32", coefs[0 +: COEFW], coefs[31*COEFW +: COEFW]);
    end
    @(posedge clk);
    #1;
    n_chk++;
    if (coef_update !== 1'b0) begin
      n_fail++;
      $display("FAIL update_pulse_width got %b want 0", coef_update);
    end
  endtask
  task automatic test_bad_frame(input int n, input string name);
    int u = upd_cnt, e = err_cnt;
    fill_random();
    send(n, 0, 0);
    n_chk++;
    if (load_err !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_err_pulse got %b want 1", name, load_err);
    end
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (err_cnt != e + 1 || upd_cnt != u) begin
      n_fail++;
      $display("FAIL %s_counts err=%0d upd=%0d want %0d %0d", name, err_cnt - e, upd_cnt - u, 1, 0);
    end
    n_chk++;
    if (coefs !== bank) begin
      n_fail++;
      $display("FAIL %s_coefs_kept got %h want %h", name, coefs, bank);
    end
  endtask
  task automatic test_good_after(input bit gaps, input string name);
    int u = upd_cnt, e = err_cnt;
    fill_random();
    send(NTAPS, gaps, 1);
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (coefs !== bank || upd_cnt != u + 1 || err_cnt != e) begin
      n_fail++;
      $display("FAIL %s coefs=%h want %h upd=%0d err=%0d want 1 0", name, coefs, bank, upd_cnt - u, err_cnt - e);
    end
  endtask
  task automatic test_reset_midframe();
    fill_random();
    for (int k = 0; k < 12; k++) begin
      put(w[k], 0);
      if (k % 3 == 1) begin
        @(posedge clk);
        #1;
      end
    end
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midframe_busy got %b want 1", busy);
    end
    #2 reset = 0;
    #1;
    bank = '0;
    n_chk++;
    if (coefs !== '0 || busy !== 1'b0 || s_coef_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midframe_reset coefs=%h busy=%b ready=%b want 0", coefs, busy, s_coef_ready);
    end
    repeat (2) @(negedge clk);
    reset = 1;
    test_good_after(1, "post_reset_frame");
  endtask
  task automatic test_symmetric();
    w[0] = COEFW'(7);
    w[1] = COEFW'(-3);
    w[2] = COEFW'(9);
    send(NL, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (coefs[3*COEFW +: COEFW] !== COEFW'(-3) || coefs[4*COEFW +: COEFW] !== COEFW'(7) ||
        coefs[2*COEFW +: COEFW] !== COEFW'(9)) begin
      n_fail++;
      $display("FAIL symmetric_taps got %h want 7,-3,9,-3,7", coefs);
    end
  endtask
  initial begin
    test_reset();
`ifdef FIR_COEF_SYMMETRIC_EN
    test_symmetric();
    test_bad_frame(2, "sym_short");
`else
    test_full_frame();
    test_bad_frame(10, "short");
    test_bad_frame(40, "long");
    test_good_after(0, "after_long_frame");
    test_reset_midframe();
`endif
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_updates got %0d want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
